// File: rtl/tile_row_prefetch.sv
// Tile row prefetcher: fills one text row of tile words from system memory into
// the back half of a double-buffered line store, then serves VGA reads from the
// front half with a fixed one-cycle latency.
module tile_row_prefetch #(
   parameter int                          SYS_DATA_WIDTH = 16,
   parameter int                          SYS_ADDR_WIDTH = 16,
   parameter int                          COLS           = 40,
   parameter int                          LOG2_COLS      = 6,
   parameter logic [SYS_ADDR_WIDTH-1:0]   TILE_BASE      = 16'hF000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      row_start,
   input  logic [LOG2_COLS-1:0]      row_idx,
   input  logic                      swap,
   output logic                      mem_rd_en,
   output logic [SYS_ADDR_WIDTH-1:0] mem_addr,
   input  logic                      mem_grant,
   input  logic [SYS_DATA_WIDTH-1:0] mem_data,
   input  logic [SYS_ADDR_WIDTH-1:0] vga_addr,
   output logic [SYS_DATA_WIDTH-1:0] vga_data,
   output logic                      busy,
   output logic                      overrun
);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   localparam logic [SYS_ADDR_WIDTH-1:0] COLS_A   = SYS_ADDR_WIDTH'(COLS);
   localparam logic [LOG2_COLS-1:0]      LAST_IDX = LOG2_COLS'(COLS - 1);

   state_t                    state, state_nx;
   logic [SYS_ADDR_WIDTH-1:0] fill_base;
   logic [SYS_ADDR_WIDTH-1:0] disp_base;
   logic [LOG2_COLS-1:0]      req_cnt;
   logic                      disp_bank;
   logic                      disp_valid;
   logic                      wr_pend;
   logic [LOG2_COLS-1:0]      wr_idx;
   logic                      do_start;
   logic                      do_flip;
   logic                      set_ovr;
   logic [SYS_ADDR_WIDTH-1:0] off;

   // Two banks: disp_bank is read by VGA, ~disp_bank is filled from memory.
   logic [SYS_DATA_WIDTH-1:0] ram [2][COLS];

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next state, bus request and control strobes
   always_comb begin
      state_nx  = state;
      do_start  = 1'b0;
      do_flip   = 1'b0;
      set_ovr   = 1'b0;
      mem_rd_en = 1'b0;
      mem_addr  = '0;
      busy      = 1'b0;
      unique case (state)
         IDLE: begin
            // A swap here just means a blank row; nothing to flip.
            if (row_start) begin
               do_start = 1'b1;
               state_nx = FETCH;
            end
         end
         FETCH: begin
            busy      = 1'b1;
            mem_rd_en = 1'b1;
            mem_addr  = fill_base + SYS_ADDR_WIDTH'(req_cnt);
            if (swap || row_start) set_ovr = 1'b1;
            if (mem_grant && req_cnt == LAST_IDX) state_nx = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (swap || row_start) set_ovr = 1'b1;
            // Final word lands this cycle.
            if (wr_pend) state_nx = DONE;
         end
         DONE: begin
            if (swap) begin
               do_flip = 1'b1;
               if (row_start) begin
                  do_start = 1'b1;
                  state_nx = FETCH;
               end else begin
                  state_nx = IDLE;
               end
            end else if (row_start) begin
               set_ovr = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Fetch bookkeeping, bank flip and sticky error flag
   always_ff @(posedge clk) begin
      if (reset) begin
         fill_base  <= TILE_BASE;
         req_cnt    <= '0;
         disp_bank  <= 1'b0;
         disp_valid <= 1'b0;
         disp_base  <= TILE_BASE;
         overrun    <= 1'b0;
         wr_pend    <= 1'b0;
         wr_idx     <= '0;
      end else begin
         if (do_start) begin
            fill_base <= TILE_BASE + SYS_ADDR_WIDTH'(row_idx) * COLS_A;
            req_cnt   <= '0;
         end else if (state == FETCH && mem_grant) begin
            req_cnt <= req_cnt + LOG2_COLS'(1);
         end
         // disp_base takes the pre-update fill_base, so a same-cycle restart is safe.
         if (do_flip) begin
            disp_bank  <= ~disp_bank;
            disp_base  <= fill_base;
            disp_valid <= 1'b1;
         end
         if (set_ovr) overrun <= 1'b1;
         // Read data trails the grant by one cycle; remember where it goes.
         wr_pend <= (state == FETCH) && mem_grant;
         wr_idx  <= req_cnt;
      end
   end

   // Fill-bank write; banks only flip in DONE, after all writes have landed
   always_ff @(posedge clk) begin
      if (wr_pend) ram[~disp_bank][wr_idx] <= mem_data;
   end

   assign off = vga_addr - disp_base;

   // VGA read port: one-cycle latency, zero outside the displayed row
   always_ff @(posedge clk) begin
      if (reset)
         vga_data <= '0;
      else if (disp_valid && off < COLS_A)
         vga_data <= ram[disp_bank][off[LOG2_COLS-1:0]];
      else
         vga_data <= '0;
   end

endmodule

// File: tb/tb_tile_row_prefetch.sv
// Directed bench for tile_row_prefetch: memory returns word == address.
module tb_tile_row_prefetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        row_start;
   logic [5:0]  row_idx;
   logic        swap;
   logic        mem_rd_en;
   logic [15:0] mem_addr;
   logic        mem_grant;
   logic [15:0] mem_data;
   logic [15:0] vga_addr;
   logic [15:0] vga_data;
   logic        busy;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] exp;
   } vec_t;
   vec_t tbl [8];

   tile_row_prefetch dut (
      .clk(clk), .reset(reset), .row_start(row_start), .row_idx(row_idx),
      .swap(swap), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
      .mem_grant(mem_grant), .mem_data(mem_data), .vga_addr(vga_addr),
      .vga_data(vga_data), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance one clock; the memory model answers a granted request next cycle.
   task automatic tick();
      logic        hit;
      logic [15:0] a;
      hit = mem_rd_en && mem_grant;
      a   = mem_addr;
      @(posedge clk);
      #1;
      mem_data = hit ? a : 16'hDEAD;
   endtask

   task automatic vga_rd(input string name, input logic [15:0] a, input logic [15:0] exp);
      vga_addr = a;
      tick();
      chk(name, {16'h0, vga_data}, {16'h0, exp});
   endtask

   // Start a fetch with grant held high and run it to DONE.
   task automatic full_fetch(input logic [5:0] r);
      row_start = 1'b1; row_idx = r; mem_grant = 1'b1;
      tick();
      row_start = 1'b0;
      for (int k = 0; k < 41; k++) tick();
   endtask

   initial begin
      int cnt;
      int cyc;
      logic g;

      tbl[0] = '{16'hF050, 16'hF050};
      tbl[1] = '{16'hF051, 16'hF051};
      tbl[2] = '{16'hF064, 16'hF064};
      tbl[3] = '{16'hF077, 16'hF077};
      tbl[4] = '{16'hF078, 16'h0000};
      tbl[5] = '{16'hF04F, 16'h0000};
      tbl[6] = '{16'h0000, 16'h0000};
      tbl[7] = '{16'hFFFF, 16'h0000};

      reset = 1'b1; row_start = 1'b0; row_idx = '0; swap = 1'b0;
      mem_grant = 1'b0; mem_data = 16'hDEAD; vga_addr = '0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_rd_en", {31'h0, mem_rd_en}, 32'h0);
      chk("rst_addr", {16'h0, mem_addr}, 32'h0);
      chk("rst_vga", {16'h0, vga_data}, 32'h0);
      chk("rst_ovr", {31'h0, overrun}, 32'h0);

      // Row 2, grant always high: 40 back-to-back requests, DONE at cycle 42.
      row_start = 1'b1; row_idx = 6'd2; mem_grant = 1'b1;
      tick();
      row_start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         chk("fetch_rd_en", {31'h0, mem_rd_en}, 32'h1);
         chk("fetch_addr", {16'h0, mem_addr}, 32'hF050 + k);
         tick();
      end
      chk("drain_busy", {31'h0, busy}, 32'h1);
      chk("drain_rd_en", {31'h0, mem_rd_en}, 32'h0);
      tick();
      chk("done_busy", {31'h0, busy}, 32'h0);
      vga_rd("pre_swap_f000", 16'hF000, 16'h0000);
      vga_rd("pre_swap_f050", 16'hF050, 16'h0000);

      swap = 1'b1; tick(); swap = 1'b0;
      for (int i = 0; i < 8; i++) vga_rd("row2_tbl", tbl[i].addr, tbl[i].exp);
      chk("row2_ovr", {31'h0, overrun}, 32'h0);

      // Swap while idle must not flip or flag.
      swap = 1'b1; tick(); swap = 1'b0;
      vga_rd("idle_swap", 16'hF052, 16'hF052);
      chk("idle_swap_ovr", {31'h0, overrun}, 32'h0);

      // Row 6 into the other bank, then swap and start row 3 in the same cycle.
      full_fetch(6'd6);
      swap = 1'b1; row_start = 1'b1; row_idx = 6'd3; vga_addr = 16'hF0F2;
      tick();
      swap = 1'b0; row_start = 1'b0;
      chk("restart_rd_en", {31'h0, mem_rd_en}, 32'h1);
      chk("restart_addr", {16'h0, mem_addr}, 32'hF078);
      chk("restart_ovr", {31'h0, overrun}, 32'h0);

      // Row 3 with grant pattern 1,0,0,1; swap lands on the final grant.
      cnt = 0; cyc = 0;
      while (cnt < 40 && cyc < 400) begin
         g = (cyc % 4 == 0) || (cyc % 4 == 3);
         mem_grant = g;
         chk("hold_addr", {16'h0, mem_addr}, 32'hF078 + cnt);
         if (cyc == 1) chk("row6_shown", {16'h0, vga_data}, 32'hF0F2);
         swap = g && (cnt == 39);
         tick();
         swap = 1'b0;
         if (g) cnt++;
         cyc++;
      end
      chk("hold_grants", cnt, 40);
      mem_grant = 1'b1;
      vga_rd("late_swap_old", 16'hF0F5, 16'hF0F5);
      chk("late_swap_ovr", {31'h0, overrun}, 32'h1);
      swap = 1'b1; tick(); swap = 1'b0;
      chk("flip_idle", {31'h0, busy}, 32'h0);
      vga_rd("row3_0", 16'hF078, 16'hF078);
      vga_rd("row3_1", 16'hF079, 16'hF079);
      vga_rd("row3_17", 16'hF089, 16'hF089);
      vga_rd("row3_39", 16'hF09F, 16'hF09F);
      vga_rd("row3_out", 16'hF0F2, 16'h0000);

      // Reset mid-fetch at req_cnt 17.
      row_start = 1'b1; row_idx = 6'd1;
      tick();
      row_start = 1'b0;
      for (int k = 0; k < 17; k++) tick();
      chk("pre_rst_addr", {16'h0, mem_addr}, 32'hF039);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("mid_rst_busy", {31'h0, busy}, 32'h0);
      chk("mid_rst_rd_en", {31'h0, mem_rd_en}, 32'h0);
      chk("mid_rst_ovr", {31'h0, overrun}, 32'h0);
      vga_rd("mid_rst_valid", 16'hF078, 16'h0000);

      // row_start in DONE without swap is ignored but flagged.
      full_fetch(6'd0);
      row_start = 1'b1; row_idx = 6'd9; tick(); row_start = 1'b0;
      chk("done_rs_ovr", {31'h0, overrun}, 32'h1);
      chk("done_rs_busy", {31'h0, busy}, 32'h0);
      chk("done_rs_rd_en", {31'h0, mem_rd_en}, 32'h0);
      swap = 1'b1; tick(); swap = 1'b0;
      vga_rd("row0_first", 16'hF000, 16'hF000);
      vga_rd("row0_last", 16'hF027, 16'hF027);
      vga_rd("row0_out", 16'hF028, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
